decoder3to8_timed: RTL and testbench

- Registered 3-to-8 one-hot decoder with a valid/ready input handshake. It is the inverse of the team's 8-to-3 one-hot encoder.
- Each accepted 3-bit code drives exactly one bit of Q high for a programmable number of cycles. A programmable all-zero blanking gap follows.
- Used to drive strobe/select lines, e.g. LED/digit selects or chip selects, from a code source. Q is glitch-free and never has two bits high at once.

---
 rtl/decoder3to8_timed_pkg.sv | 13 +
 rtl/decoder3to8_timed_decode3to8_comb.sv | 23 ++
 rtl/decoder3to8_timed.sv | 107 ++++++++++
 tb/tb_decoder3to8_timed.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/decoder3to8_timed_pkg.sv
// Shared constants and FSM state encoding for the timed 3-to-8 decoder
// and its 8-to-3 encoder counterpart.
package decoder3to8_timed_pkg;

  localparam int unsigned ONEHOT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } state_e;

endpackage

// File: rtl/decoder3to8_timed_decode3to8_comb.sv
// Pure combinational 3-bit code to one-hot decode.
module decode3to8_comb
  import decoder3to8_timed_pkg::*;
(
  input  logic [2:0]          code_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    unique case (code_i)
      3'd0: onehot_o = 8'h01;
      3'd1: onehot_o = 8'h02;
      3'd2: onehot_o = 8'h04;
      3'd3: onehot_o = 8'h08;
      3'd4: onehot_o = 8'h10;
      3'd5: onehot_o = 8'h20;
      3'd6: onehot_o = 8'h40;
      3'd7: onehot_o = 8'h80;
    endcase
  end

endmodule

// File: rtl/decoder3to8_timed.sv
// Registered 3-to-8 one-hot decoder: each accepted code holds one Q bit high
// for HOLD_CYCLES, followed by GAP_CYCLES of all-zero blanking.
module decoder3to8_timed
  import decoder3to8_timed_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [2:0]          D,
  input  logic                d_valid,
  output logic                d_ready,
  output logic [ONEHOT_W-1:0] Q,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  // Only used when GAP_CYCLES > 0, so the wrap at zero never matters.
  localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ONEHOT_W-1:0]   q_q, q_d;
  logic                  done_q, done_d;
  logic [ONEHOT_W-1:0]   code_onehot;

  decode3to8_comb u_decode (
    .code_i   (D),
    .onehot_o (code_onehot)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && d_valid) begin
          q_d     = code_onehot;
          cnt_d   = HoldLoad;
          state_d = StHold;
        end
      end
      StHold: begin
        // Abort has priority over a normal expiry on the same edge.
        if (!en) begin
          q_d     = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          q_d    = '0;
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GapLoad;
            state_d = StGap;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (!en) begin
          q_d     = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        q_d     = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign Q       = q_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  assign d_ready = rst_n && en && (state_q == StIdle);

endmodule

// File: tb/tb_decoder3to8_timed.sv
// Scoreboard bench for decoder3to8_timed: per-cycle expected outputs are queued
// as stimulus is driven and compared on the falling clock edge.
module tb_decoder3to8_timed;

  localparam int unsigned CntW  = 8;
  localparam int unsigned HoldA = 4;
  localparam int unsigned GapA  = 1;
  localparam int unsigned HoldB = 1;
  localparam int unsigned GapB  = 0;

  typedef struct packed {
    logic [7:0] q;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, d_valid, sel;
  logic [2:0] din;
  logic       ready_a, busy_a, done_a, ready_b, busy_b, done_b;
  logic [7:0] q_a, q_b;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder3to8_timed #(.HOLD_CYCLES(HoldA), .GAP_CYCLES(GapA), .CNT_W(CntW)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .D(din), .d_valid(d_valid),
    .d_ready(ready_a), .Q(q_a), .busy(busy_a), .done(done_a)
  );

  decoder3to8_timed #(.HOLD_CYCLES(HoldB), .GAP_CYCLES(GapB), .CNT_W(CntW)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .D(din), .d_valid(d_valid),
    .d_ready(ready_b), .Q(q_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("onehot0_a", 32'($onehot0(q_a)), 32'd1);
    check("onehot0_b", 32'($onehot0(q_b)), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q",     32'(sel ? q_b     : q_a),     32'(e.q));
      check("done",  32'(sel ? done_b  : done_a),  32'(e.done));
      check("busy",  32'(sel ? busy_b  : busy_a),  32'(e.busy));
      check("ready", 32'(sel ? ready_b : ready_a), 32'(e.ready));
    end
  end

  // Called right at a rising edge: drive inputs for the coming cycle, queue its
  // expected outputs, advance one cycle.
  task automatic cyc(input logic en_v, input logic dv_v, input logic [2:0] d_v,
                     input logic [7:0] eq, input logic ed, input logic eb, input logic er);
    exp_t e;
    #1;
    en      = en_v;
    d_valid = dv_v;
    din     = d_v;
    e       = '{q: eq, done: ed, busy: eb, ready: er};
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // One code: accept cycle, hold, then done/gap. abort_at >= 0 drops en in that
  // hold cycle. done_next tells the caller whether the following cycle carries done.
  task automatic send(input logic [2:0] code, input int hold, input int gap,
                      input logic first_done, input logic [2:0] d_hold, input int abort_at,
                      output logic done_next);
    logic [7:0] oh;
    oh = 8'h01 << code;
    cyc(1'b1, 1'b1, code, 8'h00, first_done, 1'b0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      if (i == abort_at) begin
        cyc(1'b0, 1'b1, d_hold, oh, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, d_hold, 8'h00, 1'b0, 1'b0, 1'b0);
        done_next = 1'b0;
        return;
      end
      cyc(1'b1, 1'b1, d_hold, oh, 1'b0, 1'b1, 1'b0);
    end
    if (gap > 0) begin
      cyc(1'b1, 1'b1, d_hold, 8'h00, 1'b1, 1'b1, 1'b0);
      for (int j = 1; j < gap; j++) cyc(1'b1, 1'b1, d_hold, 8'h00, 1'b0, 1'b1, 1'b0);
      done_next = 1'b0;
    end else begin
      done_next = 1'b1;
    end
  endtask

  initial begin
    logic dn;
    if (HoldA < 1 || HoldA - 1 >= (1 << CntW) || GapA >= (1 << CntW) ||
        HoldB < 1 || HoldB - 1 >= (1 << CntW) || GapB >= (1 << CntW)) begin
      $display("FAIL param_check: illegal HOLD/GAP for CNT_W=%0d", CntW);
      $fatal(1);
    end
    rst_n = 1'b0; en = 1'b1; d_valid = 1'b0; din = 3'd0; sel = 1'b0;
    @(posedge clk);

    // Reset held for three cycles, then released with en=1, d_valid=0.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-to-back sweep, D presented for the next code during each hold.
    dn = 1'b0;
    for (int c = 0; c < 8; c++)
      send(3'(c), HoldA, GapA, dn, 3'(c + 1), -1, dn);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, dn, 1'b0, 1'b1);

    // Input stability: D changes to 7 during the hold of code 2.
    send(3'd2, HoldA, GapA, 1'b0, 3'd7, -1, dn);
    send(3'd7, HoldA, GapA, dn, 3'd7, -1, dn);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, dn, 1'b0, 1'b1);

    // Abort on the 2nd hold cycle; en stays low a while with d_valid high.
    send(3'd6, HoldA, GapA, 1'b0, 3'd6, 1, dn);
    cyc(1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1);

    // en falls on the expiry edge: abort wins, no done.
    send(3'd4, HoldA, GapA, 1'b0, 3'd4, int'(HoldA) - 1, dn);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Short instance: HOLD=1, GAP=0.
    #1 sel = 1'b1;
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    send(3'd5, HoldB, GapB, 1'b0, 3'd0, -1, dn);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, dn, 1'b0, 1'b1);
    send(3'd3, HoldB, GapB, 1'b0, 3'd0, -1, dn);
    send(3'd0, HoldB, GapB, dn, 3'd0, -1, dn);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, dn, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a hold.
    #1 sel = 1'b0;
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd6, 8'h40, 1'b0, 1'b1, 1'b0);
    #2;
    check("pre_rst_q", 32'(q_a), 32'h40);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_q",    32'(q_a),    32'h00);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_done", 32'(done_a), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
